// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the copperv core: sequences fetch, decode,
// register-file wait, execute, memory and write-back, with a memory watchdog and sticky trap.
module mc_control_unit #(
    parameter int RF_READ_LAT  = 0,
    parameter int MEM_TIMEOUT  = 0,
    parameter int CNT_WIDTH    = 8,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              inst_type,
    input  logic                    inst_valid,
    input  logic [3:0]              funct,
    input  logic [2:0]              alu_comp,
    input  logic                    data_valid,
    output logic                    inst_fetch,
    output logic                    store_data,
    output logic                    load_data,
    output logic [1:0]              mem_width,
    output logic                    rd_en,
    output logic                    rs1_en,
    output logic                    rs2_en,
    output logic [1:0]              rd_din_sel,
    output logic [1:0]              pc_next_sel,
    output logic                    alu_din1_sel,
    output logic [1:0]              alu_din2_sel,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    trap,
    output logic [1:0]              trap_cause
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_RF_WAIT, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [3:0] T_IMM = 4'd0, T_INT_IMM = 4'd1, T_INT_REG = 4'd2, T_BRANCH = 4'd3,
                           T_STORE = 4'd4, T_LOAD = 4'd5, T_JAL = 4'd6, T_JALR = 4'd7,
                           T_AUIPC = 4'd8;
    localparam logic [1:0] PC_STALL = 2'd0, PC_INCR = 2'd1, PC_ADD_IMM = 2'd2, PC_ALU = 2'd3;
    localparam logic [1:0] RD_IMM = 2'd0, RD_ALU = 2'd1, RD_MEM = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP = '1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = '0;
    localparam logic [CNT_WIDTH-1:0] RF_LAST  = CNT_WIDTH'(RF_READ_LAT > 0 ? RF_READ_LAT - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] MEM_LAST = CNT_WIDTH'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t               state, state_next;
    logic                 first_cycle;
    logic [CNT_WIDTH-1:0] cnt;
    logic [3:0]           cur_type, cur_funct;
    logic [1:0]           cause_q, cause_next;
    logic                 branch_bad, store_bad, load_bad, take, needs_rs1, needs_rs2;

    // Instruction class and funct are captured when the fetch completes
    assign branch_bad = (cur_funct[2:1] == 2'b01);
    assign store_bad  = (cur_funct[2:0] > 3'd2);
    assign load_bad   = (cur_funct[2:0] == 3'd3) || (cur_funct[2:1] == 2'b11);
    assign needs_rs1  = (cur_type == T_INT_IMM) || (cur_type == T_INT_REG) || (cur_type == T_BRANCH) ||
                        (cur_type == T_STORE) || (cur_type == T_LOAD) || (cur_type == T_JALR);
    assign needs_rs2  = (cur_type == T_INT_REG) || (cur_type == T_BRANCH) || (cur_type == T_STORE);

    always_comb begin
        case (cur_funct[2:1])
            2'b00:   take = alu_comp[0] ^ cur_funct[0];
            2'b10:   take = alu_comp[1] ^ cur_funct[0];
            2'b11:   take = alu_comp[2] ^ cur_funct[0];
            default: take = 1'b0;
        endcase
    end

    // The shared counter times RF_WAIT and serves as the MEM watchdog; it restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            first_cycle <= 1'b0;
            cnt         <= '0;
            cause_q     <= 2'd0;
            cur_type    <= 4'd0;
            cur_funct   <= 4'd0;
        end else begin
            state       <= state_next;
            first_cycle <= (state_next != state);
            if (state_next != state)
                cnt <= '0;
            else if (state == S_RF_WAIT || (state == S_MEM && !data_valid))
                cnt <= cnt + CNT_WIDTH'(1);
            if (state == S_FETCH && inst_valid) begin
                cur_type  <= inst_type;
                cur_funct <= funct;
            end
            if (state_next == S_TRAP && state != S_TRAP)
                cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        cause_next = 2'd0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                if (inst_valid) begin
                    if (inst_type > T_AUIPC) begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end else if (inst_type == T_JAL) begin
                        state_next = S_EXEC;
                    end else begin
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (cur_type == T_IMM)
                    state_next = S_FETCH;
                else
                    state_next = (RF_READ_LAT > 0) ? S_RF_WAIT : S_EXEC;
            end
            S_RF_WAIT: if (cnt == RF_LAST) state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                if ((cur_type == T_BRANCH && branch_bad) || (cur_type == T_STORE && store_bad) ||
                    (cur_type == T_LOAD && load_bad)) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else if (cur_type == T_STORE || cur_type == T_LOAD) begin
                    state_next = S_MEM;
                end else if (cur_type == T_JALR) begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (data_valid) begin
                    state_next = S_FETCH;
                end else if (MEM_TIMEOUT > 0 && cnt == MEM_LAST) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        inst_fetch   = 1'b0;
        store_data   = 1'b0;
        load_data    = 1'b0;
        mem_width    = 2'd0;
        rd_en        = 1'b0;
        rs1_en       = 1'b0;
        rs2_en       = 1'b0;
        rd_din_sel   = RD_IMM;
        pc_next_sel  = PC_STALL;
        alu_din1_sel = 1'b0;
        alu_din2_sel = 2'd0;
        alu_op       = ALU_NOP;
        trap         = (state == S_TRAP);
        trap_cause   = cause_q;
        if ((state == S_EXEC || state == S_MEM) && (cur_type == T_STORE || cur_type == T_LOAD))
            mem_width = cur_funct[1:0];
        if (state == S_DECODE || state == S_RF_WAIT || state == S_EXEC) begin
            rs1_en = needs_rs1;
            rs2_en = needs_rs2;
        end
        case (state)
            S_FETCH: inst_fetch = first_cycle;
            S_DECODE: begin
                if (cur_type == T_IMM) begin
                    rd_en       = 1'b1;
                    rd_din_sel  = RD_IMM;
                    pc_next_sel = PC_INCR;
                end
            end
            S_EXEC: begin
                case (cur_type)
                    T_INT_IMM, T_INT_REG: begin
                        alu_op       = (cur_type == T_INT_REG) ? ALU_OP_WIDTH'(cur_funct)
                                                               : ALU_OP_WIDTH'({1'b0, cur_funct[2:0]});
                        alu_din2_sel = (cur_type == T_INT_REG) ? 2'd1 : 2'd0;
                        rd_en        = 1'b1;
                        rd_din_sel   = RD_ALU;
                        pc_next_sel  = PC_INCR;
                    end
                    T_BRANCH: begin
                        alu_din2_sel = 2'd1;
                        if (!branch_bad)
                            pc_next_sel = take ? PC_ADD_IMM : PC_INCR;
                    end
                    T_STORE, T_LOAD: begin
                        alu_op = ALU_ADD;
                        if (cur_type == T_STORE)
                            store_data = first_cycle && !store_bad;
                        else
                            load_data = first_cycle && !load_bad;
                    end
                    T_JAL, T_JALR: begin
                        alu_din1_sel = 1'b1;
                        alu_din2_sel = 2'd2;
                        alu_op       = ALU_ADD;
                        rd_en        = 1'b1;
                        rd_din_sel   = RD_ALU;
                        pc_next_sel  = (cur_type == T_JAL) ? PC_ADD_IMM : PC_STALL;
                    end
                    T_AUIPC: begin
                        alu_din1_sel = 1'b1;
                        alu_op       = ALU_ADD;
                        rd_en        = 1'b1;
                        rd_din_sel   = RD_ALU;
                        pc_next_sel  = PC_INCR;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (data_valid) begin
                    pc_next_sel = PC_INCR;
                    if (cur_type == T_LOAD) begin
                        rd_en      = 1'b1;
                        rd_din_sel = RD_MEM;
                    end
                end
            end
            // JALR target uses the ALU only after the link value has been written
            S_WB: begin
                rs1_en      = 1'b1;
                alu_op      = ALU_ADD;
                pc_next_sel = PC_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with RF_READ_LAT=2 and MEM_TIMEOUT=5.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] inst_type = 4'd0;
    logic       inst_valid = 1'b0;
    logic [3:0] funct = 4'd0;
    logic [2:0] alu_comp = 3'd0;
    logic       data_valid = 1'b0;
    logic       inst_fetch, store_data, load_data, rd_en, rs1_en, rs2_en;
    logic       alu_din1_sel, trap;
    logic [1:0] mem_width, rd_din_sel, pc_next_sel, alu_din2_sel, trap_cause;
    logic [3:0] alu_op;

    int n_compared = 0;
    int n_mismatched = 0;

    mc_control_unit #(.RF_READ_LAT(2), .MEM_TIMEOUT(5), .CNT_WIDTH(8), .ALU_OP_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .inst_type(inst_type), .inst_valid(inst_valid), .funct(funct),
        .alu_comp(alu_comp), .data_valid(data_valid), .inst_fetch(inst_fetch),
        .store_data(store_data), .load_data(load_data), .mem_width(mem_width), .rd_en(rd_en),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_din_sel(rd_din_sel), .pc_next_sel(pc_next_sel),
        .alu_din1_sel(alu_din1_sel), .alu_din2_sel(alu_din2_sel), .alu_op(alu_op),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] t, input logic [3:0] f);
        inst_type = t;
        funct = f;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic go_exec(input logic [3:0] t, input logic [3:0] f);
        fetch(t, f);
        step();
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_compared++; if (inst_fetch !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_fetch: got %0d expected 0", inst_fetch); end
        n_compared++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin n_mismatched++; $display("[TB] FAIL rst_trap: got %0d/%0d expected 0/0", trap, trap_cause); end
        n_compared++; if (alu_op !== 4'hF) begin n_mismatched++; $display("[TB] FAIL rst_alu_op: got %0d expected 15", alu_op); end
        n_compared++; if (pc_next_sel !== 2'd0 || rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_pc_rd: got %0d/%0d expected 0/0", pc_next_sel, rd_en); end
        rst = 1'b0;
        step();
        n_compared++; if (inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fetch_pulse: got %0d expected 1", inst_fetch); end
        step();
        n_compared++; if (inst_fetch !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fetch_pulse_end: got %0d expected 0", inst_fetch); end
        fetch(4'd0, 4'd0);
        n_compared++; if (rd_en !== 1'b1 || rd_din_sel !== 2'd0 || pc_next_sel !== 2'd1) begin n_mismatched++; $display("[TB] FAIL lui_decode: got rd_en=%0d sel=%0d pc=%0d expected 1/0/1", rd_en, rd_din_sel, pc_next_sel); end
        step();
        n_compared++; if (inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lui_refetch: got %0d expected 1", inst_fetch); end
    endtask

    task automatic test_int_reg();
        fetch(4'd2, 4'b1000);
        n_compared++; if (rs1_en !== 1'b1 || rs2_en !== 1'b1 || rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL intreg_decode: got rs1=%0d rs2=%0d rd=%0d expected 1/1/0", rs1_en, rs2_en, rd_en); end
        step();
        n_compared++; if (rd_en !== 1'b0 || rs2_en !== 1'b1 || alu_op !== 4'hF) begin n_mismatched++; $display("[TB] FAIL intreg_wait1: got rd=%0d rs2=%0d op=%0d expected 0/1/15", rd_en, rs2_en, alu_op); end
        step();
        n_compared++; if (rd_en !== 1'b0 || pc_next_sel !== 2'd0) begin n_mismatched++; $display("[TB] FAIL intreg_wait2: got rd=%0d pc=%0d expected 0/0", rd_en, pc_next_sel); end
        step();
        n_compared++; if (alu_op !== 4'd8 || alu_din2_sel !== 2'd1 || rd_en !== 1'b1 || rd_din_sel !== 2'd1 || pc_next_sel !== 2'd1) begin n_mismatched++; $display("[TB] FAIL intreg_exec: got op=%0d d2=%0d rd=%0d sel=%0d pc=%0d expected 8/1/1/1/1", alu_op, alu_din2_sel, rd_en, rd_din_sel, pc_next_sel); end
        step();
        n_compared++; if (inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL intreg_refetch: got %0d expected 1", inst_fetch); end
    endtask

    task automatic test_int_imm();
        fetch(4'd1, 4'b1101);
        n_compared++; if (rs1_en !== 1'b1 || rs2_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL intimm_decode: got rs1=%0d rs2=%0d expected 1/0", rs1_en, rs2_en); end
        step(); step(); step();
        n_compared++; if (alu_op !== 4'd5 || alu_din2_sel !== 2'd0 || alu_din1_sel !== 1'b0 || rd_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL intimm_exec: got op=%0d d2=%0d d1=%0d rd=%0d expected 5/0/0/1", alu_op, alu_din2_sel, alu_din1_sel, rd_en); end
        step();
    endtask

    task automatic test_branch();
        alu_comp = 3'b010;
        go_exec(4'd3, 4'b0101);
        n_compared++; if (pc_next_sel !== 2'd1 || alu_din2_sel !== 2'd1 || rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bge_not_taken: got pc=%0d d2=%0d rd=%0d expected 1/1/0", pc_next_sel, alu_din2_sel, rd_en); end
        step();
        alu_comp = 3'b000;
        go_exec(4'd3, 4'b0101);
        n_compared++; if (pc_next_sel !== 2'd2) begin n_mismatched++; $display("[TB] FAIL bge_taken: got %0d expected 2", pc_next_sel); end
        step();
        alu_comp = 3'b001;
        go_exec(4'd3, 4'b0000);
        n_compared++; if (pc_next_sel !== 2'd2) begin n_mismatched++; $display("[TB] FAIL beq_taken: got %0d expected 2", pc_next_sel); end
        step();
        alu_comp = 3'b100;
        go_exec(4'd3, 4'b0111);
        n_compared++; if (pc_next_sel !== 2'd1) begin n_mismatched++; $display("[TB] FAIL bgeu_not_taken: got %0d expected 1", pc_next_sel); end
        step();
        go_exec(4'd3, 4'b0010);
        step();
        n_compared++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin n_mismatched++; $display("[TB] FAIL branch_illegal: got %0d/%0d expected 1/1", trap, trap_cause); end
        alu_comp = 3'b000;
        do_reset();
    endtask

    task automatic test_load_jalr();
        go_exec(4'd5, 4'b0010);
        n_compared++; if (load_data !== 1'b1 || store_data !== 1'b0 || mem_width !== 2'd2 || alu_op !== 4'd0) begin n_mismatched++; $display("[TB] FAIL load_exec: got ld=%0d st=%0d w=%0d op=%0d expected 1/0/2/0", load_data, store_data, mem_width, alu_op); end
        step();
        n_compared++; if (load_data !== 1'b0 || rd_en !== 1'b0 || mem_width !== 2'd2) begin n_mismatched++; $display("[TB] FAIL load_mem_wait: got ld=%0d rd=%0d w=%0d expected 0/0/2", load_data, rd_en, mem_width); end
        step(); step(); step();
        n_compared++; if (rd_en !== 1'b0 || pc_next_sel !== 2'd0) begin n_mismatched++; $display("[TB] FAIL load_no_early_wb: got rd=%0d pc=%0d expected 0/0", rd_en, pc_next_sel); end
        data_valid = 1'b1;
        #1;
        n_compared++; if (rd_en !== 1'b1 || rd_din_sel !== 2'd2 || pc_next_sel !== 2'd1 || mem_width !== 2'd2) begin n_mismatched++; $display("[TB] FAIL load_data_valid: got rd=%0d sel=%0d pc=%0d w=%0d expected 1/2/1/2", rd_en, rd_din_sel, pc_next_sel, mem_width); end
        step();
        data_valid = 1'b0;
        #1;
        n_compared++; if (inst_fetch !== 1'b1 || rd_en !== 1'b0 || trap !== 1'b0) begin n_mismatched++; $display("[TB] FAIL load_refetch: got f=%0d rd=%0d trap=%0d expected 1/0/0", inst_fetch, rd_en, trap); end
        go_exec(4'd7, 4'd0);
        n_compared++; if (rd_en !== 1'b1 || alu_din1_sel !== 1'b1 || alu_din2_sel !== 2'd2 || alu_op !== 4'd0 || pc_next_sel !== 2'd0) begin n_mismatched++; $display("[TB] FAIL jalr_exec: got rd=%0d d1=%0d d2=%0d op=%0d pc=%0d expected 1/1/2/0/0", rd_en, alu_din1_sel, alu_din2_sel, alu_op, pc_next_sel); end
        step();
        n_compared++; if (pc_next_sel !== 2'd3 || rd_en !== 1'b0 || alu_din1_sel !== 1'b0 || alu_din2_sel !== 2'd0 || alu_op !== 4'd0) begin n_mismatched++; $display("[TB] FAIL jalr_wb: got pc=%0d rd=%0d d1=%0d d2=%0d op=%0d expected 3/0/0/0/0", pc_next_sel, rd_en, alu_din1_sel, alu_din2_sel, alu_op); end
        step();
        n_compared++; if (inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jalr_refetch: got %0d expected 1", inst_fetch); end
    endtask

    task automatic test_jal_auipc();
        fetch(4'd6, 4'd0);
        n_compared++; if (pc_next_sel !== 2'd2 || rd_en !== 1'b1 || alu_din1_sel !== 1'b1 || alu_din2_sel !== 2'd2) begin n_mismatched++; $display("[TB] FAIL jal_exec: got pc=%0d rd=%0d d1=%0d d2=%0d expected 2/1/1/2", pc_next_sel, rd_en, alu_din1_sel, alu_din2_sel); end
        step();
        go_exec(4'd8, 4'd0);
        n_compared++; if (pc_next_sel !== 2'd1 || alu_din1_sel !== 1'b1 || alu_din2_sel !== 2'd0 || rs1_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL auipc_exec: got pc=%0d d1=%0d d2=%0d rs1=%0d expected 1/1/0/0", pc_next_sel, alu_din1_sel, alu_din2_sel, rs1_en); end
        step();
    endtask

    task automatic test_store_timeout();
        go_exec(4'd4, 4'b0010);
        n_compared++; if (store_data !== 1'b1 || load_data !== 1'b0 || mem_width !== 2'd2) begin n_mismatched++; $display("[TB] FAIL store_exec: got st=%0d ld=%0d w=%0d expected 1/0/2", store_data, load_data, mem_width); end
        step(); step(); step(); step(); step();
        n_compared++; if (trap !== 1'b0 || store_data !== 1'b0) begin n_mismatched++; $display("[TB] FAIL store_mem5: got trap=%0d st=%0d expected 0/0", trap, store_data); end
        step();
        n_compared++; if (trap !== 1'b1 || trap_cause !== 2'd2 || pc_next_sel !== 2'd0) begin n_mismatched++; $display("[TB] FAIL store_timeout: got %0d/%0d pc=%0d expected 1/2/0", trap, trap_cause, pc_next_sel); end
        do_reset();
        go_exec(4'd4, 4'b0001);
        step(); step(); step(); step(); step();
        data_valid = 1'b1;
        #1;
        n_compared++; if (pc_next_sel !== 2'd1 || rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL store_ack_edge: got pc=%0d rd=%0d expected 1/0", pc_next_sel, rd_en); end
        step();
        data_valid = 1'b0;
        #1;
        n_compared++; if (trap !== 1'b0 || inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL store_ack_no_trap: got trap=%0d f=%0d expected 0/1", trap, inst_fetch); end
        go_exec(4'd4, 4'b0011);
        n_compared++; if (store_data !== 1'b0) begin n_mismatched++; $display("[TB] FAIL store_illegal_pulse: got %0d expected 0", store_data); end
        step();
        n_compared++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin n_mismatched++; $display("[TB] FAIL store_illegal_trap: got %0d/%0d expected 1/1", trap, trap_cause); end
        do_reset();
    endtask

    task automatic test_illegal();
        int bad = 0;
        fetch(4'd12, 4'd0);
        n_compared++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin n_mismatched++; $display("[TB] FAIL illegal_trap: got %0d/%0d expected 1/1", trap, trap_cause); end
        for (int i = 0; i < 20; i++) begin
            inst_valid = i[0];
            data_valid = i[1];
            step();
            if (trap !== 1'b1 || trap_cause !== 2'd1 || inst_fetch !== 1'b0 || pc_next_sel !== 2'd0) bad++;
        end
        inst_valid = 1'b0;
        data_valid = 1'b0;
        n_compared++; if (bad != 0) begin n_mismatched++; $display("[TB] FAIL trap_sticky: got %0d bad cycles expected 0", bad); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_compared++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin n_mismatched++; $display("[TB] FAIL trap_cleared: got %0d/%0d expected 0/0", trap, trap_cause); end
        step();
        n_compared++; if (inst_fetch !== 1'b1) begin n_mismatched++; $display("[TB] FAIL trap_resume: got %0d expected 1", inst_fetch); end
    endtask

    initial begin
        test_reset();
        test_int_reg();
        test_int_imm();
        test_branch();
        test_load_jalr();
        test_jal_auipc();
        test_store_timeout();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
